// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage load/store unit.
// funct3 access codes, FSM states and a funct3 legality helper.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering for the load/store unit.
// Store path builds enables and replicated data; load path extracts lanes.
module lsu_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_f3,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  input  logic [31:0] rdata,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_f3,
  output logic [31:0] ld_data
);

  logic [31:0] sh;

  always_comb begin
    be       = 4'hF;
    wdata    = wd;
    misalign = 1'b0;
    case (st_f3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << st_off;
        wdata = {4{wd[7:0]}};
      end
      F3_H, F3_HU: begin
        be       = st_off[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{wd[15:0]}};
        misalign = st_off[0];
      end
      default: begin
        be       = 4'hF;
        wdata    = wd;
        misalign = |st_off;
      end
    endcase
  end

  always_comb begin
    sh      = rdata >> {ld_off, 3'b000};
    ld_data = sh;
    case (ld_f3)
      F3_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   ld_data = {24'b0, sh[7:0]};
      F3_HU:   ld_data = {16'b0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/gnt/rvalid data-memory master.
// Stalls the pipeline while a transaction is outstanding.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              memReadM,
  input  logic              memWriteM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] aluResultM,
  input  logic [31:0]       writeDataM,
  output logic [31:0]       readDataM,
  output logic              stallM,
  output logic              errM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t state, state_n;

  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [CW:0]   cnt_inc;
  logic          tmo_hit;

  logic          access, bad, latch, tmo, cap;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n, ld_data;
  logic          misalign;

  lsu_lane_align u_align (
    .st_off   (aluResultM[1:0]),
    .st_f3    (funct3M),
    .wd       (writeDataM),
    .be       (be_n),
    .wdata    (wdata_n),
    .misalign (misalign),
    .rdata    (dmem_rdata),
    .ld_off   (off_q),
    .ld_f3    (f3_q),
    .ld_data  (ld_data)
  );

  assign access  = memReadM | memWriteM;
  assign bad     = (memReadM & memWriteM) |
                   ~f3_legal(funct3M) | misalign;
  assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
  assign tmo_hit = (MAX_WAIT != 0) &&
                   (cnt_inc == (CW+1)'(MAX_WAIT));
  assign errM    = (state == S_DONE) & err_q;

  always_comb begin
    state_n  = state;
    stallM   = 1'b0;
    dmem_req = 1'b0;
    latch    = 1'b0;
    tmo      = 1'b0;
    cap      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access) begin
          stallM  = 1'b1;
          latch   = 1'b1;
          state_n = bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        stallM   = 1'b1;
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          state_n = dmem_we ? S_DONE : S_WAIT;
        end else if (tmo_hit) begin
          state_n = S_DONE;
          tmo     = 1'b1;
        end
      end
      S_WAIT: begin
        stallM = 1'b1;
        if (dmem_rvalid) begin
          state_n = S_DONE;
          cap     = 1'b1;
        end else if (tmo_hit) begin
          state_n = S_DONE;
          tmo     = 1'b1;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      readDataM  <= '0;
    end else begin
      state <= state_n;
      if (latch) begin
        dmem_we    <= memWriteM;
        dmem_addr  <= {aluResultM[ADDR_W-1:2], 2'b00};
        dmem_be    <= be_n;
        dmem_wdata <= wdata_n;
        off_q      <= aluResultM[1:0];
        f3_q       <= funct3M;
        err_q      <= bad;
      end
      // Counter restarts per phase so REQ and WAIT each get the full budget
      if (latch || (state == S_REQ && dmem_gnt)) begin
        cnt_q <= '0;
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt_q <= cnt_inc[CW-1:0];
      end
      if (cap) begin
        readDataM <= ld_data;
      end
      if (tmo) begin
        readDataM <= '0;
        err_q     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, random ops vs. a
// behavioural model, and an async-reset-in-WAIT sequence.
module tb_mem_access_unit;

  localparam int MW = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        memReadM, memWriteM;
  logic [2:0]  funct3M;
  logic [31:0] aluResultM, writeDataM;
  logic [31:0] readDataM;
  logic        stallM, errM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  mem_access_unit #(.ADDR_W(32), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .memReadM(memReadM), .memWriteM(memWriteM),
    .funct3M(funct3M), .aluResultM(aluResultM),
    .writeDataM(writeDataM), .readDataM(readDataM),
    .stallM(stallM), .errM(errM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
  } op_t;

  typedef struct {
    logic        err;
    int          stall;
    int          req;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  typedef struct {
    logic        done;
    logic        err;
    logic        early_err;
    logic        unstable;
    logic        we;
    int          stall;
    int          req;
    int          wait_c;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr,
      input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] wd, input logic [31:0] rdata,
      input int gdly, input int rdly, input logic err,
      input int stall, input int req, input logic [3:0] be,
      input logic [31:0] wdata, input logic [31:0] rdv);
    vec_t v;
    v.op = '{rd, wr, f3, addr, wd, rdata, gdly, rdly};
    v.e  = '{err, stall, req, be, wdata, rdv};
    return v;
  endfunction

  // Reference: outcome of one access from the access rules alone
  function automatic exp_t model(input op_t op, input logic [31:0] prev);
    exp_t e;
    int sz, off;
    logic legal, bad;
    logic [31:0] v, mask;
    off   = int'(op.addr[1:0]);
    sz    = (op.f3[1:0] == 2'd0) ? 1 : (op.f3[1:0] == 2'd1) ? 2 : 4;
    legal = op.f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bad   = !legal || (op.rd && op.wr) || ((off % sz) != 0);
    e.be  = 4'(((1 << sz) - 1) << off);
    if (sz == 1)      e.wdata = {24'b0, op.wd[7:0]} * 32'h0101_0101;
    else if (sz == 2) e.wdata = {16'b0, op.wd[15:0]} * 32'h0001_0001;
    else              e.wdata = op.wd;
    e.err = 1'b0; e.rd = prev; e.req = 0; e.stall = 0;
    if (bad) begin
      e.err = 1'b1; e.stall = 1;
    end else if (op.gdly >= MW) begin
      e.err = 1'b1; e.stall = 1 + MW; e.req = MW; e.rd = 0;
    end else begin
      e.req = op.gdly + 1;
      if (op.wr) begin
        e.stall = 2 + op.gdly;
      end else if (op.rdly < 0 || op.rdly >= MW) begin
        e.err = 1'b1; e.stall = 2 + op.gdly + MW; e.rd = 0;
      end else begin
        e.stall = 3 + op.gdly + op.rdly;
        v = op.rdata >> (8 * off);
        mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
        v = v & mask;
        if (!op.f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        e.rd = v;
      end
    end
    return e;
  endfunction

  // Drives one access and plays the memory side with the given delays
  task automatic run_op(input op_t op, output obs_t o);
    bit granted;
    o = '{default: 0};
    granted = 0;
    @(negedge CLK);
    memReadM = op.rd; memWriteM = op.wr; funct3M = op.f3;
    aluResultM = op.addr; writeDataM = op.wd; dmem_rdata = op.rdata;
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!stallM) begin
        o.done = 1; o.err = errM; o.rd = readDataM;
        break;
      end
      o.stall++;
      if (errM) o.early_err = 1;
      if (dmem_req) begin
        if (o.req == 0) begin
          o.be = dmem_be; o.addr = dmem_addr;
          o.wdata = dmem_wdata; o.we = dmem_we;
        end else if (dmem_be !== o.be || dmem_addr !== o.addr ||
                     dmem_wdata !== o.wdata || dmem_we !== o.we) begin
          o.unstable = 1;
        end
        o.req++;
        if (o.req == op.gdly + 1) begin
          dmem_gnt = 1'b1; granted = 1;
        end
      end else if (granted) begin
        o.wait_c++;
        if (op.rdly >= 0 && o.wait_c == op.rdly + 1) dmem_rvalid = 1'b1;
      end
      @(posedge CLK); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      @(negedge CLK); #1;
    end
    memReadM = 1'b0; memWriteM = 1'b0;
  endtask

  task automatic check_op(input string tag, input op_t op,
                          input obs_t o, input exp_t e);
    chk({tag, ".done"}, 32'(o.done), 32'd1);
    chk({tag, ".stall"}, 32'(o.stall), 32'(e.stall));
    chk({tag, ".req"}, 32'(o.req), 32'(e.req));
    chk({tag, ".err"}, 32'(o.err), 32'(e.err));
    chk({tag, ".rdata"}, o.rd, e.rd);
    chk({tag, ".err_early"}, 32'(o.early_err), 32'd0);
    if (e.req > 0) begin
      chk({tag, ".be"}, 32'(o.be), 32'(e.be));
      chk({tag, ".addr"}, o.addr, {op.addr[31:2], 2'b00});
      chk({tag, ".we"}, 32'(o.we), 32'(op.wr));
      chk({tag, ".stable"}, 32'(o.unstable), 32'd0);
      if (op.wr) chk({tag, ".wdata"}, o.wdata, e.wdata);
    end
  endtask

  vec_t tbl[12];
  op_t  op;
  obs_t ob;
  exp_t ex;
  logic [31:0] model_rd;

  initial begin
    RST_N = 1'b0;
    memReadM = 0; memWriteM = 0; funct3M = 0;
    aluResultM = 0; writeDataM = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;

    tbl[0]  = mk(1,0,3'b000,32'h1003,0,32'h80FF_FF00,0,0,
                 0,3,1,4'b1000,0,32'hFFFF_FF80);
    tbl[1]  = mk(0,1,3'b001,32'h2002,32'h0000_BEEF,0,1,0,
                 0,3,2,4'b1100,32'hBEEF_BEEF,32'hFFFF_FF80);
    tbl[2]  = mk(1,0,3'b010,32'h0006,0,0,0,0,
                 1,1,0,4'hF,0,32'hFFFF_FF80);
    tbl[3]  = mk(1,0,3'b101,32'h0010,0,32'h1234_8001,0,0,
                 0,3,1,4'b0011,0,32'h0000_8001);
    tbl[4]  = mk(0,1,3'b010,32'h0020,32'hDEAD_BEEF,0,0,0,
                 0,2,1,4'hF,32'hDEAD_BEEF,32'h0000_8001);
    tbl[5]  = mk(1,0,3'b010,32'h0040,0,32'h5555_5555,0,-1,
                 1,6,1,4'hF,0,32'h0);
    tbl[6]  = mk(1,0,3'b011,32'h0000,0,0,0,0,
                 1,1,0,4'hF,0,32'h0);
    tbl[7]  = mk(1,1,3'b010,32'h0044,0,0,0,0,
                 1,1,0,4'hF,0,32'h0);
    tbl[8]  = mk(1,0,3'b001,32'h0102,0,32'h8001_0000,2,1,
                 0,6,3,4'b1100,0,32'hFFFF_8001);
    tbl[9]  = mk(0,1,3'b000,32'h0031,32'h0000_00A5,0,0,0,
                 0,2,1,4'b0010,32'hA5A5_A5A5,32'hFFFF_8001);
    tbl[10] = mk(1,0,3'b100,32'h0032,0,32'h00C3_0000,0,0,
                 0,3,1,4'b0100,0,32'h0000_00C3);
    tbl[11] = mk(0,1,3'b000,32'h0050,32'h77,0,9,0,
                 1,5,4,4'b0001,32'h7777_7777,32'h0);

    @(negedge CLK);
    chk("rst.stall", 32'(stallM), 0);
    chk("rst.req", 32'(dmem_req), 0);
    chk("rst.we", 32'(dmem_we), 0);
    chk("rst.be", 32'(dmem_be), 0);
    chk("rst.addr", dmem_addr, 0);
    chk("rst.wdata", dmem_wdata, 0);
    chk("rst.rdata", readDataM, 0);
    chk("rst.err", 32'(errM), 0);
    #2 RST_N = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, ob);
      check_op($sformatf("tbl%0d", i), tbl[i].op, ob, tbl[i].e);
    end
    model_rd = tbl[11].e.rd;

    for (int i = 0; i < 150; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      op.rd = (r <= 5); op.wr = (r == 0) || (r >= 6);
      if ($urandom_range(0, 9) < 8) begin
        r = int'($urandom_range(0, 4));
        op.f3 = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 :
                (r == 2) ? 3'b010 : (r == 3) ? 3'b100 : 3'b101;
      end else begin
        op.f3 = 3'($urandom);
      end
      op.addr = $urandom; op.wd = $urandom; op.rdata = $urandom;
      op.gdly = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
      op.rdly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      ex = model(op, model_rd);
      run_op(op, ob);
      check_op($sformatf("rnd%0d", i), op, ob, ex);
      model_rd = ex.rd;
    end

    op = '{1'b1, 1'b0, 3'b010, 32'h84, 32'h0, 32'h1122_3344, 0, 0};
    ex = model(op, model_rd);
    run_op(op, ob);
    check_op("pre_rst", op, ob, ex);

    // Reset while a load sits in WAIT; the late rvalid must be ignored
    @(negedge CLK);
    memReadM = 1; funct3M = 3'b010; aluResultM = 32'h80;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    dmem_gnt = 1'b1;
    @(negedge CLK);
    dmem_gnt = 1'b0; memReadM = 1'b0;
    #1 chk("wrst.stall_in_wait", 32'(stallM), 1);
    chk("wrst.req_in_wait", 32'(dmem_req), 0);
    RST_N = 1'b0;
    #1 chk("wrst.req", 32'(dmem_req), 0);
    chk("wrst.stall", 32'(stallM), 0);
    chk("wrst.rdata", readDataM, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    dmem_rvalid = 1'b1;
    @(negedge CLK);
    dmem_rvalid = 1'b0;
    #1 chk("wrst.late_stall", 32'(stallM), 0);
    chk("wrst.late_rdata", readDataM, 0);
    chk("wrst.late_err", 32'(errM), 0);
    chk("wrst.late_req", 32'(dmem_req), 0);
    model_rd = 32'h0;

    op = '{1'b1, 1'b0, 3'b000, 32'h91, 32'h0, 32'h0000_7F00, 1, 2};
    ex = model(op, model_rd);
    run_op(op, ob);
    check_op("post_rst", op, ob, ex);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
